// File: rtl/nvram_uploader.sv
// nvram_uploader: pauses the board and streams battery-backed NVRAM to the HPS over ioctl upload,
// tracking whether NVRAM has changed since the last complete save.
module nvram_uploader #(
   parameter logic [7:0] NV_INDEX = 8'd4,
   parameter int AW = 8,
   parameter int RAM_LAT = 1
) (
   input  logic          clk_sys,
   input  logic          reset,
   input  logic          ioctl_upload,
   input  logic [7:0]    ioctl_index,
   input  logic          ioctl_rd,
   input  logic [24:0]   ioctl_addr,
   output logic [7:0]    ioctl_din,
   output logic          ioctl_wait,
   output logic          pause_req,
   input  logic          pause_ack,
   output logic [AW-1:0] nv_addr,
   output logic          nv_rd,
   input  logic [7:0]    nv_q,
   input  logic          cpu_nv_we,
   output logic          nv_dirty,
   output logic          busy
);
   typedef enum logic [2:0] {IDLE, PAUSE, READY, FETCH, LATCH, DONE} state_t;
   localparam logic [AW:0] NV_SIZE = {1'b1, {AW{1'b0}}};
   state_t state, nxt;
   logic up_d, oor, start, in_range;
   logic [1:0] lat_cnt;
   logic [AW:0] cnt;
   always_comb begin
      start = ioctl_upload && !up_d && ioctl_index == NV_INDEX;
      in_range = ioctl_addr[24:AW] == '0;
      nxt = state;
      case (state)
         IDLE:    nxt = start ? PAUSE : IDLE;
         PAUSE:   nxt = pause_ack ? READY : PAUSE;
         READY:   nxt = !pause_ack ? PAUSE : !ioctl_rd ? READY : in_range ? FETCH : LATCH;
         FETCH:   nxt = lat_cnt == 2'(RAM_LAT - 1) ? LATCH : FETCH;
         LATCH:   nxt = READY;
         default: nxt = IDLE;
      endcase
      // losing the session abandons whatever is in flight
      if (state != IDLE && state != DONE && !ioctl_upload) nxt = DONE;
   end
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         up_d       <= 1'b0;
         oor        <= 1'b0;
         lat_cnt    <= 2'd0;
         cnt        <= '0;
         ioctl_din  <= 8'd0;
         ioctl_wait <= 1'b0;
         pause_req  <= 1'b0;
         nv_addr    <= '0;
         nv_rd      <= 1'b0;
         nv_dirty   <= 1'b0;
         busy       <= 1'b0;
      end else begin
         state      <= nxt;
         up_d       <= ioctl_upload;
         pause_req  <= nxt != IDLE;
         ioctl_wait <= nxt == PAUSE || nxt == FETCH || nxt == LATCH;
         busy       <= state != IDLE || nxt != IDLE;
         nv_rd      <= state == READY && nxt == FETCH;
         lat_cnt    <= state == FETCH ? lat_cnt + 2'd1 : 2'd0;
         if (state == IDLE) cnt <= '0;
         if (state == READY && (nxt == FETCH || nxt == LATCH)) begin
            nv_addr <= ioctl_addr[AW-1:0];
            oor     <= !in_range;
         end
         if (state == LATCH && nxt == READY) begin
            ioctl_din <= oor ? 8'hFF : nv_q;
            if (!oor && cnt != NV_SIZE) cnt <= cnt + 1'b1;
         end
         // a CPU write always wins over the clear at the end of a full save
         nv_dirty <= cpu_nv_we || (nv_dirty && !(state == DONE && cnt == NV_SIZE));
      end
   end
endmodule

// File: tb/tb_nvram_uploader.sv
// tb_nvram_uploader: directed + randomized upload sessions against an array model of NVRAM.
module tb_nvram_uploader;
   logic        clk_sys = 1'b0;
   logic        reset = 1'b1;
   logic        ioctl_upload = 1'b0;
   logic [7:0]  ioctl_index = 8'd0;
   logic        ioctl_rd = 1'b0;
   logic [24:0] ioctl_addr = '0;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait, pause_req, pause_ack, nv_rd, nv_dirty, busy;
   logic [7:0]  nv_addr;
   logic [7:0]  nv_q = 8'd0;
   logic        cpu_nv_we = 1'b0;
   logic [7:0]  mem [256];
   logic [2:0]  ack_sr = 3'd0;
   int total = 0, bad = 0, rd_pulses = 0, exp_cnt = 0;
   logic exp_dirty = 1'b0;
   logic [7:0] exp_din = 8'd0;

   nvram_uploader #(.NV_INDEX(8'd4), .AW(8), .RAM_LAT(1)) dut (
      .clk_sys(clk_sys), .reset(reset), .ioctl_upload(ioctl_upload), .ioctl_index(ioctl_index),
      .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr), .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
      .pause_req(pause_req), .pause_ack(pause_ack), .nv_addr(nv_addr), .nv_rd(nv_rd), .nv_q(nv_q),
      .cpu_nv_we(cpu_nv_we), .nv_dirty(nv_dirty), .busy(busy)
   );

   always #10 clk_sys = ~clk_sys;
   // board acknowledges a pause three cycles after it is requested
   always @(posedge clk_sys) ack_sr <= {ack_sr[1:0], pause_req};
   assign pause_ack = ack_sr[2];
   always @(posedge clk_sys) if (nv_rd) nv_q <= mem[nv_addr];
   always @(posedge clk_sys) if (nv_rd) rd_pulses <= rd_pulses + 1;

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_write(input logic [7:0] a, input logic [7:0] d);
      mem[a] = d;
      cpu_nv_we = 1'b1;
      step();
      cpu_nv_we = 1'b0;
      exp_dirty = 1'b1;
      chk("dirty_set", {31'd0, nv_dirty}, {31'd0, exp_dirty});
   endtask

   task automatic start_session();
      int n;
      ioctl_index = 8'd4;
      ioctl_upload = 1'b1;
      exp_cnt = 0;
      step();
      chk("start_pause", {31'd0, pause_req}, 32'd1);
      chk("start_wait", {31'd0, ioctl_wait}, 32'd1);
      chk("start_busy", {31'd0, busy}, 32'd1);
      n = 0;
      while (ioctl_wait && n < 20) begin
         n++;
         step();
      end
      chk("ready_reached", {31'd0, ioctl_wait}, 32'd0);
   endtask

   task automatic read_byte(input int addr);
      int w, p0;
      p0 = rd_pulses;
      ioctl_addr = 25'(addr);
      ioctl_rd = 1'b1;
      step();
      ioctl_rd = 1'b0;
      w = 0;
      while (ioctl_wait && w < 20) begin
         w++;
         step();
      end
      exp_din = addr < 256 ? mem[addr] : 8'hFF;
      if (addr < 256) exp_cnt++;
      chk($sformatf("din@%0d", addr), {24'd0, ioctl_din}, {24'd0, exp_din});
      chk($sformatf("wait@%0d", addr), w, addr < 256 ? 2 : 1);
      chk($sformatf("nvrd@%0d", addr), rd_pulses - p0, addr < 256 ? 1 : 0);
   endtask

   task automatic end_session(input logic we_in_done);
      ioctl_upload = 1'b0;
      step();
      chk("end_pause_hold", {31'd0, pause_req}, 32'd1);
      cpu_nv_we = we_in_done;
      step();
      cpu_nv_we = 1'b0;
      chk("end_pause_low", {31'd0, pause_req}, 32'd0);
      chk("end_busy_hold", {31'd0, busy}, 32'd1);
      step();
      chk("end_busy_low", {31'd0, busy}, 32'd0);
      if (we_in_done) exp_dirty = 1'b1;
      else if (exp_cnt >= 256) exp_dirty = 1'b0;
      chk("end_dirty", {31'd0, nv_dirty}, {31'd0, exp_dirty});
      repeat (4) step();
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_din"}, {24'd0, ioctl_din}, 32'd0);
      chk({tag, "_wait"}, {31'd0, ioctl_wait}, 32'd0);
      chk({tag, "_pause"}, {31'd0, pause_req}, 32'd0);
      chk({tag, "_addr"}, {24'd0, nv_addr}, 32'd0);
      chk({tag, "_nvrd"}, {31'd0, nv_rd}, 32'd0);
      chk({tag, "_dirty"}, {31'd0, nv_dirty}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
      step();
      step();
      check_reset_vals("reset");
      reset = 1'b0;
      step();
      cpu_write(8'd17, 8'(17) ^ 8'h5A);
      start_session();
      for (int a = 0; a < 256; a++) read_byte(a);
      end_session(1'b0);
      cpu_write(8'($urandom), 8'($urandom));
      start_session();
      for (int i = 0; i < 100; i++) read_byte(int'($urandom_range(0, 400)));
      end_session(1'b0);
      start_session();
      read_byte(300);
      read_byte(255);
      read_byte(256);
      end_session(1'b0);
      ioctl_index = 8'd0;
      ioctl_upload = 1'b1;
      for (int i = 0; i < 8; i++) begin
         ioctl_rd = i[0];
         ioctl_addr = 25'(i);
         step();
         chk("idx0_pause", {31'd0, pause_req}, 32'd0);
         chk("idx0_wait", {31'd0, ioctl_wait}, 32'd0);
         chk("idx0_busy", {31'd0, busy}, 32'd0);
      end
      ioctl_rd = 1'b0;
      ioctl_upload = 1'b0;
      repeat (2) step();
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      start_session();
      read_byte(int'($urandom_range(0, 255)));
      ioctl_addr = 25'd42;
      ioctl_rd = 1'b1;
      step();
      ioctl_rd = 1'b0;
      end_session(1'b0);
      chk("abort_din", {24'd0, ioctl_din}, {24'd0, exp_din});
      start_session();
      for (int a = 0; a < 256; a++) read_byte(a);
      end_session(1'b1);
      start_session();
      ioctl_addr = 25'd9;
      ioctl_rd = 1'b1;
      step();
      ioctl_rd = 1'b0;
      ioctl_upload = 1'b0;
      reset = 1'b1;
      step();
      check_reset_vals("midreset");
      reset = 1'b0;
      exp_dirty = 1'b0;
      step();
      start_session();
      for (int i = 0; i < 20; i++) read_byte(int'($urandom_range(0, 300)));
      end_session(1'b0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/nvram_uploader.md
# nvram_uploader

Serves HPS save requests for the board's battery-backed NVRAM (high scores, bookkeeping) over the ioctl upload channel, the core-to-HPS counterpart of the ROM/DIP download path. Sits in the emu top next to hps_io. Pauses the game CPU, reads NVRAM through a spare read port and returns bytes on `ioctl_din` under `ioctl_wait` flow control. Also tracks whether NVRAM changed since the last full save.

## Interface
- `NV_INDEX`, 8'd4: ioctl_index value that selects NVRAM upload.
- `AW`, 8: NVRAM address width; NV_SIZE = 2**AW bytes.
- `RAM_LAT`, 1: cycles from `nv_rd` to valid `nv_q` (1..3).

- `clk_sys` in 1: system clock (50 MHz).
- `reset` in 1: asynchronous, active-high reset.
- `ioctl_upload` in 1: HPS upload session active.
- `ioctl_index` in 8: session file index.
- `ioctl_rd` in 1: one-cycle byte request strobe.
- `ioctl_addr` in 25: byte address of request.
- `ioctl_din` out 8: returned byte.
- `ioctl_wait` out 1: HPS must hold off while high.
- `pause_req` out 1: halt request to CPU/board.
- `pause_ack` in 1: CPU halted, NVRAM port free.
- `nv_addr` out AW: NVRAM read address.
- `nv_rd` out 1: one-cycle NVRAM read strobe.
- `nv_q` in 8: NVRAM read data.
- `cpu_nv_we` in 1: CPU NVRAM write strobe (dirty tracking).
- `nv_dirty` out 1: NVRAM modified since last complete upload.
- `busy` out 1: high in any state except IDLE.

## Operation
- Session = `ioctl_upload` high with `ioctl_index == NV_INDEX`; sampled on rising edge of `ioctl_upload`. Other indices ignored entirely (outputs stay idle).
- States: IDLE, PAUSE, READY, FETCH, LATCH, DONE.
- IDLE → PAUSE on session start: `pause_req`=1, `ioctl_wait`=1, byte counter cleared.
- PAUSE → READY when `pause_ack`=1; `ioctl_wait` drops on entry to READY.
- READY: on `ioctl_rd`, capture `ioctl_addr`. If addr < NV_SIZE → FETCH: `nv_addr`=addr[AW-1:0], `nv_rd`=1 for one cycle, `ioctl_wait`=1. If addr ≥ NV_SIZE → LATCH directly with data 8'hFF, no `nv_rd`.
- FETCH: count RAM_LAT cycles, then LATCH.
- LATCH: `ioctl_din` ← `nv_q` (or FF), in-range byte counter +1 (saturating at NV_SIZE), `ioctl_wait`=0, back to READY.
- Any state except IDLE: `ioctl_upload` falling → DONE (in-flight fetch abandoned, `ioctl_din` unchanged). DONE: drop `pause_req`; if counter == NV_SIZE clear `nv_dirty`; → IDLE next cycle.
- `ioctl_rd` while not in READY (incl. PAUSE) is ignored; HPS obeys `ioctl_wait`.
- `pause_ack` dropping mid-session: finish current byte, then hold `ioctl_wait`=1 in PAUSE until re-acked.
- Dirty: `cpu_nv_we` sets `nv_dirty`; set wins over a same-cycle clear in DONE.

## Timing
- Reset values: `ioctl_din`=0, `ioctl_wait`=0, `pause_req`=0, `nv_addr`=0, `nv_rd`=0, `nv_dirty`=0, `busy`=0, state IDLE.
- All outputs registered.
- Session start: `pause_req` and `ioctl_wait` high 1 cycle after the `ioctl_upload` rising edge.
- In-range read: `ioctl_rd` at cycle 0 → `nv_rd` and `ioctl_wait` high at cycle 1 → `ioctl_din` valid and `ioctl_wait` low at cycle 2+RAM_LAT. `ioctl_wait` is high for exactly RAM_LAT+1 cycles.
- Out-of-range read: `ioctl_wait` high for 1 cycle; FF valid at cycle 2.
- Max throughput: one byte per RAM_LAT+2 cycles.
- Session end: `pause_req` low 2 cycles after the `ioctl_upload` falling edge; `busy` low 1 cycle later.

## Test plan
- RAM_LAT=1, NVRAM preloaded addr→addr^8'h5A, `pause_ack` 3 cycles after `pause_req`, read 0..255 → each `ioctl_din`=addr^5A; `ioctl_wait` 2 cycles per byte; `pause_req` low after upload ends.
- CPU writes NVRAM (`nv_dirty`=1); full 256-byte upload → `nv_dirty`=0 after DONE. Repeat with only 100 bytes read → `nv_dirty` stays 1.
- Read addr 300 with AW=8 → `ioctl_din`=FF, no `nv_rd` pulse, `ioctl_wait` high 1 cycle.
- `ioctl_upload` with index 0 → `pause_req`, `ioctl_wait`, `busy` stay 0 throughout.
- `ioctl_upload` drops during FETCH → `ioctl_din` unchanged, `pause_req` low 2 cycles later; `cpu_nv_we` in the DONE cycle of a full upload leaves `nv_dirty`=1.
- Assert `reset` mid-FETCH → all outputs at reset values on the next edge; new session afterwards runs normally.
